// File: rtl/execute_muldiv_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package execute_muldiv_unit_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/execute_muldiv_unit_sign_fix.sv
// Combinational operand conditioning (IDLE) and result sign fix/select (FIX).
module muldiv_sign_fix
  import execute_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [2:0]       i_f3_in,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_neg_q,
  output logic             o_neg_r,
  output logic             o_special,
  output logic [WIDTH-1:0] o_spec_val,
  input  logic [2:0]       i_f3_fix,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic             i_neg_q,
  input  logic             i_neg_r,
  output logic [WIDTH-1:0] o_fix_val
);
  logic             w_sgn_a, w_sgn_b, w_b0, w_ovf;
  logic [2*WIDTH-1:0] w_prod, w_prod_f;
  logic [WIDTH-1:0] w_quo, w_rem;

  // Only signed operand positions contribute a sign bit.
  assign w_sgn_a = i_srca[WIDTH-1] &
                   (i_f3_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
  assign w_sgn_b = i_srcb[WIDTH-1] & (i_f3_in inside {F3_MULH, F3_DIV, F3_REM});
  assign o_mag_a = w_sgn_a ? -i_srca : i_srca;
  assign o_mag_b = w_sgn_b ? -i_srcb : i_srcb;
  assign o_neg_q = w_sgn_a ^ w_sgn_b;
  assign o_neg_r = w_sgn_a;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign w_b0      = (i_srcb == '0);
  assign w_ovf     = (i_f3_in inside {F3_DIV, F3_REM}) &&
                     (i_srca == {1'b1, {(WIDTH-1){1'b0}}}) && (i_srcb == '1);
  assign o_special = i_f3_in[2] & (w_b0 | w_ovf);
  assign o_spec_val = w_b0 ? (i_f3_in[1] ? i_srca : '1)
                           : (i_f3_in[1] ? '0 : i_srca);

  // Product sign shares the quotient sign flag; remainder follows dividend.
  assign w_prod   = {i_hi, i_lo};
  assign w_prod_f = i_neg_q ? -w_prod : w_prod;
  assign w_quo    = i_neg_q ? -i_lo : i_lo;
  assign w_rem    = i_neg_r ? -i_hi : i_hi;

  always_comb begin
    o_fix_val = '0;
    if (!i_f3_fix[2]) o_fix_val = (i_f3_fix == F3_MUL) ? w_prod_f[WIDTH-1:0]
                                                      : w_prod_f[2*WIDTH-1:WIDTH];
    else              o_fix_val = i_f3_fix[1] ? w_rem : w_quo;
  end
endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M mul/div: radix-2 shift-add multiply and restoring divide
// sharing one accumulator (hi/remainder) and one shift register (lo/quotient).
module execute_muldiv_unit
  import execute_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CNTW  = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  input  logic [4:0]       i_rde,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [4:0]       o_rdout
);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH-1);

  state_t           r_state, w_next;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_acc, r_mq, r_mcand, r_result;
  logic [2:0]       r_f3;
  logic [4:0]       r_rd, r_rdout;
  logic             r_neg_q, r_neg_r;

  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_spec_val, w_fix_val;
  logic             w_neg_q, w_neg_r, w_special, w_go;
  logic [WIDTH:0]   w_sum, w_shift;
  logic [WIDTH-1:0] w_acc_nxt, w_mq_nxt;
  logic             w_ge;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_f3_in(i_funct3), .i_srca(i_srca), .i_srcb(i_srcb),
    .o_mag_a(w_mag_a), .o_mag_b(w_mag_b), .o_neg_q(w_neg_q), .o_neg_r(w_neg_r),
    .o_special(w_special), .o_spec_val(w_spec_val),
    .i_f3_fix(r_f3), .i_hi(r_acc), .i_lo(r_mq),
    .i_neg_q(r_neg_q), .i_neg_r(r_neg_r), .o_fix_val(w_fix_val)
  );

  assign w_go     = i_start & ~i_flush;
  assign o_busy   = ~i_rst & ((r_state == S_IDLE & w_go) |
                              (r_state == S_CALC) | (r_state == S_FIX));
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_rdout  = r_rdout;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state; flush overrides everything.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_flush) w_next = S_IDLE;
  end

  // One iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
  always_comb begin
    w_sum     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
    w_shift   = {r_acc, r_mq[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_mcand});
    w_acc_nxt = w_sum[WIDTH:1];
    w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
    if (r_f3[2]) begin
      w_acc_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_mcand) : w_shift[WIDTH-1:0];
      w_mq_nxt  = {r_mq[WIDTH-2:0], w_ge};
    end
  end

  // Datapath and output registers; outputs are nonzero only during DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0; r_acc <= '0; r_mq <= '0; r_mcand <= '0;
      r_f3 <= '0; r_rd <= '0; r_neg_q <= 1'b0; r_neg_r <= 1'b0;
      r_result <= '0; r_rdout <= '0;
    end else begin
      r_result <= '0;
      r_rdout  <= '0;
      case (r_state)
        S_IDLE: if (w_go) begin
          r_cnt   <= '0;
          r_acc   <= '0;
          r_mq    <= w_mag_a;
          r_mcand <= w_mag_b;
          r_f3    <= i_funct3;
          r_rd    <= i_rde;
          r_neg_q <= w_neg_q;
          r_neg_r <= w_neg_r;
          if (w_special) begin
            r_result <= w_spec_val;
            r_rdout  <= i_rde;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNTW'(1);
          r_acc <= w_acc_nxt;
          r_mq  <= w_mq_nxt;
        end
        S_FIX: if (!i_flush) begin
          r_result <= w_fix_val;
          r_rdout  <= r_rd;
        end
        default: ;
      endcase
    end
  end
endmodule
